// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target endpoint.
package i2c_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b1001100;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_LOAD,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_slv_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer with rise/fall pulses for one I2C pad line.
// I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter (+2 clk latency).
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Idle bus level is high, so reset to 1 to avoid a false edge on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], din};
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;
  logic       filt_d;

  always_comb begin
    filt_d = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      filt_q <= filt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= level;
  end

  assign rise_c = level & ~prev_q;
  assign fall_c = ~level & prev_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: START/STOP decode, 7-bit address match, byte-pointer mapped
// register/memory access. Optional input filter via I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = DATA_W,
  parameter int unsigned ADDRWIDTH  = ADDR_W,
  parameter logic [6:0]  SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic                 busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_c, stop_c;

  i2c_sync_edge u_scl_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (scl_in),
    .level (scl_lvl),
    .rise_c(scl_rise),
    .fall_c(scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sda_in),
    .level (sda_lvl),
    .rise_c(sda_rise),
    .fall_c(sda_fall)
  );

  // An SDA edge coinciding with an SCL edge is data, not a bus condition.
  assign start_c = sda_fall & scl_lvl & ~scl_rise;
  assign stop_c  = sda_rise & scl_lvl & ~scl_rise;

  i2c_slv_state_t       state_q, state_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic [DATAWIDTH-1:0] shreg_q, shreg_d;
  logic [ADDRWIDTH-1:0] ptr_q, ptr_d;
  logic                 first_q, first_d;
  logic                 rw_q, rw_d;
  logic                 cap_q, cap_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 mem_we_q, mem_we_d;
  logic                 mem_re_q, mem_re_d;
  logic [ADDRWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATAWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                 busy_q, busy_d;
  logic [DATAWIDTH-1:0] rx_byte;
  logic                 last_bit;

  assign rx_byte  = {shreg_q[DATAWIDTH-2:0], sda_lvl};
  assign last_bit = (bitcnt_q == 4'(DATAWIDTH - 1));

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    ptr_d       = ptr_q;
    first_d     = first_q;
    rw_d        = rw_q;
    cap_d       = mem_re_q;
    sda_oe_d    = sda_oe_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;

    // Pointer advances the cycle after the write strobe.
    if (mem_we_q) ptr_d = ptr_q + ADDRWIDTH'(1);

    if (stop_c) begin
      state_d  = ST_IDLE;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_c) begin
      state_d  = ST_ADDR;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise) begin
            shreg_d  = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (last_bit) begin
              bitcnt_d = 4'd0;
              if (rx_byte[DATAWIDTH-1:1] == SLAVE_ADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = rx_byte[0];
                first_d = ~rx_byte[0];
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) sda_oe_d = ~I2C_ACK;
          else if (scl_rise) state_d = rw_q ? ST_RD_LOAD : ST_WR_BYTE;
        end
        ST_WR_BYTE: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            shreg_d  = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (last_bit) begin
              bitcnt_d = 4'd0;
              state_d  = ST_WR_ACK;
              if (first_q) begin
                ptr_d   = ADDRWIDTH'(rx_byte);
                first_d = 1'b0;
              end else begin
                mem_we_d    = 1'b1;
                mem_addr_d  = ptr_q;
                mem_wdata_d = rx_byte;
              end
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) sda_oe_d = ~I2C_ACK;
          else if (scl_rise) state_d = ST_WR_BYTE;
        end
        ST_RD_LOAD: begin
          mem_re_d   = 1'b1;
          mem_addr_d = ptr_q;
          bitcnt_d   = 4'd0;
          state_d    = ST_RD_BYTE;
        end
        ST_RD_BYTE: begin
          // Read data lands one clk after the strobe; SCL stays high meanwhile.
          if (cap_q) begin
            shreg_d = mem_rdata;
          end else if (scl_fall) begin
            if (bitcnt_q == 4'(DATAWIDTH)) begin
              sda_oe_d = 1'b0;
              bitcnt_d = 4'd0;
              state_d  = ST_RD_ACK;
            end else begin
              sda_oe_d = ~shreg_q[DATAWIDTH-1];
              shreg_d  = {shreg_q[DATAWIDTH-2:0], 1'b0};
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              ptr_d   = ptr_q + ADDRWIDTH'(1);
              state_d = ST_RD_LOAD;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_WAIT_STOP: sda_oe_d = 1'b0;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 4'd0;
      shreg_q     <= '0;
      ptr_q       <= '0;
      first_q     <= 1'b0;
      rw_q        <= 1'b0;
      cap_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      ptr_q       <= ptr_d;
      first_q     <= first_d;
      rw_q        <= rw_d;
      cap_q       <= cap_d;
      sda_oe_q    <= sda_oe_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: bit-banged I2C master, wired-AND SDA, small read ROM.
module tb_i2c_slave_responder;

  localparam int Q = 4;

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       busy;

  int vectors;
  int errors;

  logic [15:0] we_log[$];
  logic [7:0]  re_log[$];
  int          oe_cnt;

  i2c_slave_responder u_dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_m),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sda_in = sda_m & ~sda_oe;

  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'h20:   rom = 8'h3C;
      8'h21:   rom = 8'hC3;
      default: rom = 8'hEE;
    endcase
  endfunction

  always @(posedge clk) if (mem_re) mem_rdata <= rom(mem_addr);

  initial oe_cnt = 0;
  always @(negedge clk) begin
    if (mem_we) we_log.push_back({mem_addr, mem_wdata});
    if (mem_re) re_log.push_back(mem_addr);
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; wq(2*Q); scl_m = 1'b0;
  endtask

  task automatic rep_start();
    wq(Q); sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b0; wq(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(Q); sda_m = 1'b0; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b1; wq(2*Q);
  endtask

  task automatic write_bit(input logic b);
    wq(Q); sda_m = b; wq(Q); scl_m = 1'b1; wq(2*Q); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    wq(Q); sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); ack = sda_in; wq(Q); scl_m = 1'b0;
  endtask

  task automatic recv_byte(input logic ack_in, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      wq(Q); sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); d[i] = sda_in; wq(Q); scl_m = 1'b0;
    end
    wq(Q); sda_m = ack_in; wq(Q); scl_m = 1'b1; wq(2*Q); scl_m = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    wq(3); rst = 1'b0; wq(4);
    vectors++; if (sda_oe !== 1'b0)    begin errors++; $display("FAIL reset_sda_oe got %b exp 0", sda_oe); end
    vectors++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    vectors++; if (mem_re !== 1'b0)    begin errors++; $display("FAIL reset_mem_re got %b exp 0", mem_re); end
    vectors++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got %h exp 00", mem_addr); end
    vectors++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata got %h exp 00", mem_wdata); end
    vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_write();
    logic [3:0] acks;
    int wb, rb;
    wb = we_log.size(); rb = re_log.size();
    i2c_start();
    send_byte(8'h98, acks[3]); send_byte(8'h10, acks[2]);
    send_byte(8'hA5, acks[1]); send_byte(8'h5A, acks[0]);
    vectors++; if (acks !== 4'b0000) begin errors++; $display("FAIL write_acks got %b exp 0000", acks); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_high got %b exp 1", busy); end
    i2c_stop();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_low got %b exp 0", busy); end
    vectors++; if (we_log.size() - wb !== 2) begin errors++; $display("FAIL write_we_count got %0d exp 2", we_log.size() - wb); end
    vectors++; if (we_log[wb] !== 16'h10A5) begin errors++; $display("FAIL write_first got %h exp 10A5", we_log[wb]); end
    vectors++; if (we_log[wb+1] !== 16'h115A) begin errors++; $display("FAIL write_second got %h exp 115A", we_log[wb+1]); end
    vectors++; if (re_log.size() - rb !== 0) begin errors++; $display("FAIL write_no_re got %0d exp 0", re_log.size() - rb); end
  endtask

  task automatic test_read_rs();
    logic [2:0] acks;
    logic [7:0] d0, d1;
    int wb, rb;
    wb = we_log.size(); rb = re_log.size();
    i2c_start();
    send_byte(8'h98, acks[2]); send_byte(8'h20, acks[1]);
    rep_start();
    send_byte(8'h99, acks[0]);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    wq(4*Q);
    i2c_stop();
    vectors++; if (acks !== 3'b000) begin errors++; $display("FAIL read_acks got %b exp 000", acks); end
    vectors++; if (d0 !== 8'h3C) begin errors++; $display("FAIL read_byte0 got %h exp 3C", d0); end
    vectors++; if (d1 !== 8'hC3) begin errors++; $display("FAIL read_byte1 got %h exp C3", d1); end
    vectors++; if (re_log.size() - rb !== 2) begin errors++; $display("FAIL read_re_count got %0d exp 2", re_log.size() - rb); end
    vectors++; if (re_log[rb] !== 8'h20) begin errors++; $display("FAIL read_re_addr0 got %h exp 20", re_log[rb]); end
    vectors++; if (re_log[rb+1] !== 8'h21) begin errors++; $display("FAIL read_re_addr1 got %h exp 21", re_log[rb+1]); end
    vectors++; if (we_log.size() - wb !== 0) begin errors++; $display("FAIL read_no_we got %0d exp 0", we_log.size() - wb); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_low got %b exp 0", busy); end
  endtask

  task automatic test_mismatch();
    logic [1:0] acks;
    int wb, rb, ob;
    wb = we_log.size(); rb = re_log.size(); ob = oe_cnt;
    i2c_start();
    send_byte(8'h90, acks[1]); send_byte(8'h55, acks[0]);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy got %b exp 0", busy); end
    i2c_stop();
    vectors++; if (acks !== 2'b11) begin errors++; $display("FAIL mismatch_nacks got %b exp 11", acks); end
    vectors++; if (oe_cnt - ob !== 0) begin errors++; $display("FAIL mismatch_sda_oe got %0d cycles exp 0", oe_cnt - ob); end
    vectors++; if (we_log.size() - wb !== 0) begin errors++; $display("FAIL mismatch_we got %0d exp 0", we_log.size() - wb); end
    vectors++; if (re_log.size() - rb !== 0) begin errors++; $display("FAIL mismatch_re got %0d exp 0", re_log.size() - rb); end
  endtask

  task automatic test_wrap();
    logic [3:0] acks;
    int wb;
    wb = we_log.size();
    i2c_start();
    send_byte(8'h98, acks[3]); send_byte(8'hFF, acks[2]);
    send_byte(8'h11, acks[1]); send_byte(8'h22, acks[0]);
    i2c_stop();
    vectors++; if (acks !== 4'b0000) begin errors++; $display("FAIL wrap_acks got %b exp 0000", acks); end
    vectors++; if (we_log.size() - wb !== 2) begin errors++; $display("FAIL wrap_we_count got %0d exp 2", we_log.size() - wb); end
    vectors++; if (we_log[wb] !== 16'hFF11) begin errors++; $display("FAIL wrap_first got %h exp FF11", we_log[wb]); end
    vectors++; if (we_log[wb+1] !== 16'h0022) begin errors++; $display("FAIL wrap_second got %h exp 0022", we_log[wb+1]); end
  endtask

  task automatic test_reset_mid_ack();
    logic [7:0] b;
    logic [2:0] acks;
    logic found;
    int wb;
    b = 8'h98;
    found = 1'b0;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (sda_oe === 1'b1) found = 1'b1;
    end
    vectors++; if (found !== 1'b1) begin errors++; $display("FAIL midack_wait_oe got %b exp 1", found); end
    rst = 1'b1;
    #1;
    vectors++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL midack_sda_oe got %b exp 0", sda_oe); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL midack_busy got %b exp 0", busy); end
    sda_m = 1'b1; wq(1); scl_m = 1'b1; wq(4);
    rst = 1'b0; wq(4);
    wb = we_log.size();
    i2c_start();
    send_byte(8'h98, acks[2]); send_byte(8'h40, acks[1]); send_byte(8'h77, acks[0]);
    i2c_stop();
    vectors++; if (acks !== 3'b000) begin errors++; $display("FAIL midack_next_acks got %b exp 000", acks); end
    vectors++; if (we_log.size() - wb !== 1) begin errors++; $display("FAIL midack_next_we_count got %0d exp 1", we_log.size() - wb); end
    vectors++; if (we_log[wb] !== 16'h4077) begin errors++; $display("FAIL midack_next_write got %h exp 4077", we_log[wb]); end
  endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic ack;
    int ob;
    ob = oe_cnt;
    wq(2);
    sda_m = 1'b0; @(negedge clk); sda_m = 1'b1;
    wq(2*Q);
    scl_m = 1'b0;
    send_byte(8'h98, ack);
    i2c_stop();
    vectors++; if (ack !== 1'b1) begin errors++; $display("FAIL glitch_no_ack got %b exp 1", ack); end
    vectors++; if (oe_cnt - ob !== 0) begin errors++; $display("FAIL glitch_sda_oe got %0d cycles exp 0", oe_cnt - ob); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_write();
    test_read_rs();
    test_mismatch();
    test_wrap();
    test_reset_mid_ack();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
